// File: rtl/de0_pkg.sv
// Shared definitions for the DE0 switch/button front end.
package de0_pkg;

    // Board system clock frequency.
    localparam int unsigned CLK_HZ = 50_000_000;

    // Per-channel debounce states: settled high, waiting to accept low,
    // settled low, waiting to accept high.
    typedef enum logic [1:0] {
        STABLE_HI = 2'd0,
        PEND_LO   = 2'd1,
        STABLE_LO = 2'd2,
        PEND_HI   = 2'd3
    } db_state_e;

endpackage : de0_pkg

// File: rtl/debounce_channel.sv
// Single-bit debouncer: 2-flop synchroniser, stability FSM with sample
// counter, registered clean level and one-cycle rise/fall strobes.
module debounce_channel
    import de0_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic        RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic switch_i,
    output logic level_o,
    output logic fall_o,
    output logic rise_o
);

    // The counter only ever holds 0 .. DEBOUNCE_CYCLES-1.
    localparam int unsigned     CW          = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_ZERO    = '0;
    localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam db_state_e       RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    logic            sync1_q;
    logic            sync2_q;
    db_state_e       state_q;
    logic [CW-1:0]   cnt_q;
    logic            level_q;
    logic            fall_q;
    logic            rise_q;

    // Synchroniser, debounce FSM and registered outputs in one clocked process.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
            state_q <= RESET_STATE;
            cnt_q   <= CNT_ZERO;
            level_q <= RESET_LEVEL;
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= switch_i;
            sync2_q <= sync1_q;
            // Strobes last a single cycle; only an accepted change raises one.
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
            case (state_q)
                STABLE_HI: begin
                    if (!sync2_q) begin
                        // First low sample counts as sample number one.
                        state_q <= PEND_LO;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= CNT_ZERO;
                    end
                end
                PEND_LO: begin
                    if (sync2_q) begin
                        // Bounce back high before the window filled: reject.
                        state_q <= STABLE_HI;
                        cnt_q   <= CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_LO;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                        cnt_q   <= CNT_ZERO;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                STABLE_LO: begin
                    if (sync2_q) begin
                        state_q <= PEND_HI;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= CNT_ZERO;
                    end
                end
                PEND_HI: begin
                    if (!sync2_q) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_HI;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                        cnt_q   <= CNT_ZERO;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= RESET_STATE;
                    level_q <= RESET_LEVEL;
                    cnt_q   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;
    assign rise_o  = rise_q;

endmodule : debounce_channel

// File: rtl/switch_debounce.sv
// Multi-channel debounce front end: one independent debounce_channel per pin.
module switch_debounce
    import de0_pkg::*;
#(
    parameter int unsigned NUM_SWITCHES    = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic        RESET_LEVEL     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_SWITCHES-1:0] i_Switch,
    output logic [NUM_SWITCHES-1:0] o_Switch,
    output logic [NUM_SWITCHES-1:0] o_Fall,
    output logic [NUM_SWITCHES-1:0] o_Rise
);

    for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .switch_i (i_Switch[g]),
            .level_o  (o_Switch[g]),
            .fall_o   (o_Fall[g]),
            .rise_o   (o_Rise[g])
        );
    end

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=4, two channels.
// Edge numbering: inputs change 1 ns after edge 0; edge 1 is the first edge
// that samples them, so an accepted change shows after edge 6.
module tb_switch_debounce;

    localparam int unsigned N = 2;
    localparam int unsigned D = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] i_Switch;
    logic [N-1:0] o_Switch;
    logic [N-1:0] o_Fall;
    logic [N-1:0] o_Rise;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] sw_in;
        logic [1:0] exp_sw;
        logic [1:0] exp_fall;
        logic [1:0] exp_rise;
    } vec_t;

    vec_t vecs [16];

    switch_debounce #(
        .NUM_SWITCHES    (N),
        .DEBOUNCE_CYCLES (D),
        .RESET_LEVEL     (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_Switch (i_Switch),
        .o_Switch (o_Switch),
        .o_Fall   (o_Fall),
        .o_Rise   (o_Rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] sw,
                             input logic [1:0] fall, input logic [1:0] rise);
        check({tag, " o_Switch"}, o_Switch, sw);
        check({tag, " o_Fall"},   o_Fall,   fall);
        check({tag, " o_Rise"},   o_Rise,   rise);
    endtask

    initial begin
        // Table: ch0 drops after edge 0 (accepted at edge 6), then rises
        // after edge 8 (accepted at edge 14). Entry k is sampled after edge k+1.
        for (int k = 0; k < 16; k++) begin
            vecs[k].sw_in    = (k < 8) ? 2'b10 : 2'b11;
            vecs[k].exp_sw   = (k >= 5 && k < 13) ? 2'b10 : 2'b11;
            vecs[k].exp_fall = (k == 5)  ? 2'b01 : 2'b00;
            vecs[k].exp_rise = (k == 13) ? 2'b01 : 2'b00;
        end

        // 1. Reset for 3 clocks with both pins released.
        rst_n    = 1'b0;
        i_Switch = 2'b11;
        repeat (3) tick();
        check_all("reset", 2'b11, 2'b00, 2'b00);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check_all("idle", 2'b11, 2'b00, 2'b00);
        end

        // 2 + 4. Table-driven fall then rise on ch0.
        for (int k = 0; k < 16; k++) begin
            i_Switch = vecs[k].sw_in;
            tick();
            check_all($sformatf("vec%0d", k), vecs[k].exp_sw, vecs[k].exp_fall, vecs[k].exp_rise);
        end
        repeat (4) tick();

        // 3. Bounce ch0 with 1, 2 and 3 clock low pulses, then hold high.
        begin
            logic [8:0] bounce;
            bounce = 9'b100010010; // bit i = ch0 level on cycle i (LSB first)
            for (int c = 0; c < 9; c++) begin
                i_Switch = {1'b1, bounce[c]};
                tick();
                check_all($sformatf("bounce%0d", c), 2'b11, 2'b00, 2'b00);
            end
            i_Switch = 2'b11;
            for (int c = 0; c < 8; c++) begin
                tick();
                check_all($sformatf("settle%0d", c), 2'b11, 2'b00, 2'b00);
            end
        end

        // 5. Both channels drop on the same edge.
        i_Switch = 2'b00;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check_all($sformatf("both_e%0d", e),
                      (e >= 6) ? 2'b00 : 2'b11,
                      (e == 6) ? 2'b11 : 2'b00,
                      2'b00);
        end
        i_Switch = 2'b11;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check_all($sformatf("both_up_e%0d", e),
                      (e >= 6) ? 2'b11 : 2'b00,
                      2'b00,
                      (e == 6) ? 2'b11 : 2'b00);
        end
        repeat (3) tick();

        // 6. Drop ch1, reset at edge 4 mid-pending, pin stays low.
        i_Switch = 2'b01;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check_all($sformatf("prerst_e%0d", e), 2'b11, 2'b00, 2'b00);
        end
        rst_n = 1'b0;
        tick();
        check_all("rst_e4", 2'b11, 2'b00, 2'b00);
        rst_n = 1'b1;
        for (int e = 5; e <= 12; e++) begin
            tick();
            check_all($sformatf("postrst_e%0d", e),
                      (e >= 10) ? 2'b01 : 2'b11,
                      (e == 10) ? 2'b10 : 2'b00,
                      2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_switch_debounce
